udp_cmd_sync_fifo: RTL and testbench
====================================

# udp_cmd_sync_fifo

Single-clock, first-word-fall-through-free (standard-read) FIFO for 33-bit UDP command words. The UDP receive path writes parsed command words in and the command executor reads them out, both in the same clock domain. Depth is 512 entries with programmable almost-full and almost-empty thresholds. Simulation requires no global-reset primitive; all state is cleared by `rst`.

## Interface
- DATA_WIDTH, 33, word width for both write and read sides
- ADDR_WIDTH, 9, log2 of depth (depth = 512)
- ALMOST_FULL_NUM, 450, occupancy at or above which almost_full asserts
- ALMOST_EMPTY_NUM, 30, occupancy at or below which almost_empty asserts

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- wr_data  in  DATA_WIDTH  write word
- wr_en  in  1  write request
- wr_full  out  1  FIFO holds 512 words
- almost_full  out  1  occupancy >= ALMOST_FULL_NUM
- rd_data  out  DATA_WIDTH  read word
- rd_en  in  1  read request
- rd_empty  out  1  FIFO holds 0 words
- almost_empty  out  1  occupancy <= ALMOST_EMPTY_NUM

## Operation
- Storage: 512 x 33 array; write pointer, read pointer, occupancy counter (ADDR_WIDTH+1 bits, range 0..512).
- Write accepted when wr_en=1 and wr_full=0: wr_data stored at write pointer, pointer increments (wraps 511->0).
- Read accepted when rd_en=1 and rd_empty=0: word at read pointer loaded into rd_data register, pointer increments (wraps 511->0).
- Write while full: ignored, no state change, no error flag. Read while empty: ignored, rd_data holds previous value.
- Simultaneous accepted write and read: both pointers advance, occupancy unchanged.
- Simultaneous wr_en and rd_en while full: read accepted, write dropped (flags evaluated on current state). While empty: write accepted, read dropped.
- Occupancy: +1 on write-only, -1 on read-only, unchanged otherwise.
- Flags derived from registered occupancy: wr_full = (count==512), rd_empty = (count==0), almost_full = (count>=450), almost_empty = (count<=30).
- Data order strictly FIFO; no data corruption across pointer wrap.

## Timing
- Reset (rst=1 at a rising edge): pointers and count = 0; wr_full=0, almost_full=0, rd_empty=1, almost_empty=1, rd_data=0. rst dominates wr_en/rd_en in the same cycle.
- Write latency: word written at edge N is readable via rd_en sampled at edge N+1 (rd_empty deasserts after edge N).
- Read latency 1: rd_en sampled at edge N -> rd_data valid after edge N, held until next accepted read. No output register stage, no read clock-enable.
- Flags update on the same edge that changes occupancy; reflect state visible to the next request.
- Writing 512 consecutive words from empty: wr_full asserts after the 512th accepting edge; almost_full asserts after the 450th.

## Test plan
- Reset then idle -> rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_data=0.
- 513 back-to-back writes of 0x1_FFFF_FFFF, 0x1_FFFF_FFFE, ... -> first 512 stored, wr_full=1 after 512th, 513th dropped; almost_full=1 from 450th write on; almost_empty=0 after 31st.
- Then 513 back-to-back reads -> rd_data one cycle after each rd_en equals 0x1_FFFF_FFFF descending to 0x1_FFFF_FE00; rd_empty=1 after 512th; 513th read ignored, rd_data holds 0x1_FFFF_FE00.
- Fill to 256, then 1000 cycles of simultaneous wr_en/rd_en with incrementing data -> count stays 256, output sequence continuous, pointers wrap correctly.
- When full, assert wr_en and rd_en together -> oldest word read, new word dropped, count 511, wr_full=0.
- Assert rst mid-stream with 100 words stored -> next edge clears all state to reset values; subsequent write/read returns only post-reset data.

Source files
------------

// File: rtl/udp_cmd_sync_fifo.sv
// udp_cmd_sync_fifo: single-clock standard-read FIFO for 33-bit UDP command
// words. Occupancy counter drives full/empty and programmable almost flags;
// rd_data is a register loaded only on an accepted read.
module udp_cmd_sync_fifo #(
  parameter int unsigned DATA_WIDTH       = 33,
  parameter int unsigned ADDR_WIDTH       = 9,
  parameter int unsigned ALMOST_FULL_NUM  = 450,
  parameter int unsigned ALMOST_EMPTY_NUM = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  rd_empty,
  output logic                  almost_empty
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_full_q, almost_full_q, rd_empty_q, almost_empty_q;
  logic                  wr_fire, rd_fire;

  // Accept decisions are taken on the current (registered) flags, so a
  // simultaneous request while full reads only and while empty writes only.
  assign wr_fire = wr_en & ~wr_full_q;
  assign rd_fire = rd_en & ~rd_empty_q;

  // Next-state for pointers, occupancy and the read data register.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_fire) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and flags; flags are registered from count_d so they
  // change on the same edge as the occupancy they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      wr_full_q      <= 1'b0;
      almost_full_q  <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      wr_full_q      <= (count_d == FULL_CNT);
      almost_full_q  <= (count_d >= AF_CNT);
      rd_empty_q     <= (count_d == '0);
      almost_empty_q <= (count_d <= AE_CNT);
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  assign wr_full      = wr_full_q;
  assign almost_full  = almost_full_q;
  assign rd_empty     = rd_empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_udp_cmd_sync_fifo.sv
// Testbench for udp_cmd_sync_fifo: queue-based reference model checked every
// cycle, plus hand-computed literal expectations at the interesting points.
module tb_udp_cmd_sync_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [32:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic        almost_full;
  logic [32:0] rd_data;
  logic        rd_en;
  logic        rd_empty;
  logic        almost_empty;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          chk_en = 1'b0;

  logic [32:0] q[$];
  logic [32:0] exp_rd = '0;

  always #5 clk = ~clk;

  udp_cmd_sync_fifo #(
    .DATA_WIDTH(33),
    .ADDR_WIDTH(9),
    .ALMOST_FULL_NUM(450),
    .ALMOST_EMPTY_NUM(30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .wr_full(wr_full),
    .almost_full(almost_full),
    .rd_data(rd_data),
    .rd_en(rd_en),
    .rd_empty(rd_empty),
    .almost_empty(almost_empty)
  );

  // Reference model: a plain queue with acceptance judged on pre-edge size.
  always @(posedge clk) begin
    bit full_now, empty_now;
    if (rst) begin
      q.delete();
      exp_rd = '0;
    end else begin
      full_now  = (q.size() == 512);
      empty_now = (q.size() == 0);
      if (rd_en && !empty_now) exp_rd = q.pop_front();
      if (wr_en && !full_now) q.push_back(wr_data);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (rd_data !== exp_rd || wr_full !== (q.size() == 512) ||
          rd_empty !== (q.size() == 0) || almost_full !== (q.size() >= 450) ||
          almost_empty !== (q.size() <= 30)) begin
        n_err++;
        $display("FAIL model t=%0t: got rd_data=%h full=%b af=%b empty=%b ae=%b, need rd_data=%h occupancy=%0d",
                 $time, rd_data, wr_full, almost_full, rd_empty, almost_empty, exp_rd, q.size());
      end
    end
  end

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic [32:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    @(negedge clk);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    step(1'b0, '0, 1'b0);
    check("reset_empty", rd_empty, 1'b1);
    check("reset_ae", almost_empty, 1'b1);
    check("reset_full", wr_full, 1'b0);
    check("reset_af", almost_full, 1'b0);
    check("reset_rd_data", rd_data, 33'h0);

    // 513 descending writes; the last one must be dropped.
    for (int i = 1; i <= 513; i++) begin
      step(1'b1, 33'h1_FFFF_FFFF - 33'(i - 1), 1'b0);
      if (i == 30)  check("ae_at_30", almost_empty, 1'b1);
      if (i == 31)  check("ae_at_31", almost_empty, 1'b0);
      if (i == 449) check("af_at_449", almost_full, 1'b0);
      if (i == 450) check("af_at_450", almost_full, 1'b1);
      if (i == 511) check("full_at_511", wr_full, 1'b0);
      if (i == 512) check("full_at_512", wr_full, 1'b1);
    end
    step(1'b0, '0, 1'b0);

    // 513 reads; the last one is ignored and rd_data holds.
    for (int i = 1; i <= 513; i++) begin
      step(1'b0, '0, 1'b1);
      if (i == 1)   check("first_read", rd_data, 33'h1_FFFF_FFFF);
      if (i == 512) check("last_read", rd_data, 33'h1_FFFF_FE00);
      if (i == 512) check("empty_after_512", rd_empty, 1'b1);
    end
    check("read_while_empty_holds", rd_data, 33'h1_FFFF_FE00);

    // Fill to 256, then 1000 simultaneous write/read cycles across the wrap.
    for (int i = 0; i < 256; i++) step(1'b1, 33'(i), 1'b0);
    for (int i = 256; i < 1256; i++) step(1'b1, 33'(i), 1'b1);
    check("stream_last", rd_data, 33'd999);
    check("stream_not_empty", rd_empty, 1'b0);

    // Top up to full, then simultaneous write+read: read wins, write dropped.
    for (int i = 0; i < 256; i++) step(1'b1, 33'd2000 + 33'(i), 1'b0);
    check("topped_full", wr_full, 1'b1);
    step(1'b1, 33'h0ABC, 1'b1);
    check("full_rw_oldest", rd_data, 33'd1000);
    check("full_rw_not_full", wr_full, 1'b0);
    for (int i = 0; i < 511; i++) step(1'b0, '0, 1'b1);
    check("full_rw_drop", rd_data, 33'd2255);
    check("drained_empty", rd_empty, 1'b1);

    // Mid-stream reset with 100 words stored; rst beats wr_en/rd_en.
    for (int i = 0; i < 100; i++) step(1'b1, 33'h1_0000_0000 + 33'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    check("pre_reset_read", rd_data, 33'h1_0000_0000);
    rst = 1'b1;
    step(1'b1, 33'h1_2345_6789, 1'b1);
    rst = 1'b0;
    check("post_reset_rd_data", rd_data, 33'h0);
    check("post_reset_empty", rd_empty, 1'b1);
    check("post_reset_ae", almost_empty, 1'b1);
    step(1'b1, 33'h155, 1'b0);
    step(1'b0, '0, 1'b1);
    check("post_reset_data", rd_data, 33'h155);
    step(1'b0, '0, 1'b1);
    check("post_reset_hold", rd_data, 33'h155);
    check("post_reset_empty2", rd_empty, 1'b1);

    step(1'b0, '0, 1'b0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1);
  end

endmodule
